// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin delay-timer arbiter.
package timer_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_CW   = 8;
  localparam int unsigned MAX_NREQ = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef logic [2:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  // First asserted request scanning ptr, ptr+1, ... modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input idx_t ptr,
                                    input int unsigned nreq = DEF_NREQ);
    pick_t       p;
    int unsigned c;
    p = '{valid: 1'b0, idx: '0};
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      c = (32'(ptr) + k) % nreq;
      if (!p.valid && k < nreq && req[c[2:0]]) begin
        p.valid = 1'b1;
        p.idx   = c[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle of the timer arbiter: requests/delays in, grant status out.
interface timer_arbiter_if
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dly;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      cnt;

  modport master (
    output req, dly,
    input  gnt, done, busy, cnt
  );

  modport slave (
    input  req, dly,
    output gnt, done, busy, cnt
  );
endinterface

// File: rtl/timer_core.sv
// Loadable down counter that saturates at zero.
module timer_core #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer among NREQ requesters.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW
) (
  input  logic            clk,
  input  logic            rst,
  timer_arbiter_if.slave  bus
);
  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  idx_t               ptr_q, ptr_d;
  idx_t               owner_q, owner_d;
  logic               load, dec, cnt_zero;
  logic [CW-1:0]      load_val;
  logic [CW-1:0]      cnt;
  logic [MAX_NREQ-1:0]    req_pad;
  logic [MAX_NREQ*CW-1:0] dly_pad;
  pick_t              pick;

  // Pad to the package width so 3-bit indices are always in range.
  assign req_pad = MAX_NREQ'(bus.req);
  assign dly_pad = (MAX_NREQ*CW)'(bus.dly);
  assign pick    = rr_pick(req_pad, ptr_q, NREQ);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = dly_pad[pick.idx*CW +: CW];
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          owner_d = pick.idx;
          state_d = RUN;
          for (int unsigned i = 0; i < NREQ; i++)
            gnt_d[i] = (pick.idx == idx_t'(i));
        end
      end
      RUN: begin
        // Abort and expiry release identically; only done differs.
        if (!req_pad[owner_q] || cnt_zero) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == idx_t'(NREQ-1)) ? '0 : owner_q + idx_t'(1);
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  timer_core #(.CW(CW)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign bus.gnt  = gnt_q;
  assign bus.done = gnt_q & bus.req & {NREQ{cnt_zero}};
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt;
endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: directed scenarios then random traffic vs a reference model.
module tb_timer_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 8;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [CW-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

  timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the timer, how many ticks remain, whose turn is next.
  int              m_busy = 0, m_owner = 0, m_cnt = 0, m_ptr = 0;
  int              w;
  logic [NREQ-1:0]    s_req;
  logic [NREQ*CW-1:0] s_dly;
  logic               s_rst;
  exp_t               e_new;

  always @(posedge clk) begin
    s_req = bus.req;
    s_dly = bus.dly;
    s_rst = rst;
    if (s_rst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        w = (m_ptr + k) % NREQ;
        if (m_busy == 0 && s_req[w]) begin
          m_busy  = 1;
          m_owner = w;
          m_cnt   = int'(s_dly[w*CW +: CW]);
        end
      end
    end else if (!s_req[m_owner] || m_cnt == 0) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else begin
      m_cnt = m_cnt - 1;
    end
    #2;
    e_new.gnt  = (m_busy != 0) ? NREQ'(1 << m_owner) : '0;
    e_new.busy = (m_busy != 0);
    e_new.cnt  = CW'(m_cnt);
    e_new.done = (m_busy != 0 && m_cnt == 0 && bus.req[m_owner]) ? e_new.gnt : '0;
    q.push_back(e_new);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t e_cur;
  always @(negedge clk) begin
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: no expected entry at %0t (got gnt %0h expected an entry)", $time, bus.gnt);
    end else begin
      e_cur = q.pop_front();
      chk("gnt",  32'(bus.gnt),  32'(e_cur.gnt));
      chk("done", 32'(bus.done), 32'(e_cur.done));
      chk("busy", 32'(bus.busy), 32'(e_cur.busy));
      chk("cnt",  32'(bus.cnt),  32'(e_cur.cnt));
    end
  end

  function automatic logic [NREQ*CW-1:0] dv(input int i, input int v);
    logic [NREQ*CW-1:0] d;
    d = '0;
    d[i*CW +: CW] = CW'(v);
    return d;
  endfunction

  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] d,
                       input logic rs, input int n);
    bus.req = r;
    bus.dly = d;
    rst     = rs;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [NREQ*CW-1:0] d_all;
  logic [NREQ*CW-1:0] d_rnd;

  initial begin
    drive('0, '0, 1'b1, 2);
    // single requester, delay 3
    drive(4'b0010, dv(1, 3), 1'b0, 5);
    drive('0, '0, 1'b0, 2);
    // zero delay
    drive(4'b0100, dv(2, 0), 1'b0, 2);
    drive('0, '0, 1'b0, 2);
    // round robin, all delays 1
    for (int i = 0; i < NREQ; i++) d_all[i*CW +: CW] = CW'(1);
    drive(4'b1111, d_all, 1'b0, 15);
    drive('0, '0, 1'b0, 2);
    // abort at cnt 6, then 1 wins over 3
    drive(4'b0001, dv(0, 10), 1'b0, 5);
    drive(4'b1010, dv(1, 2) | dv(3, 2), 1'b0, 6);
    drive('0, '0, 1'b0, 2);
    // reset mid-run, then pointer back at 0
    drive(4'b1000, dv(3, 5), 1'b0, 4);
    drive(4'b1000, dv(3, 5), 1'b1, 1);
    drive(4'b1001, dv(0, 2) | dv(3, 2), 1'b0, 4);
    drive('0, '0, 1'b0, 2);
    // max delay with dly changed after grant
    drive(4'b0001, dv(0, 255), 1'b0, 2);
    drive(4'b0001, dv(0, 4), 1'b0, 255);
    drive('0, '0, 1'b0, 3);
    // random traffic
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < NREQ; i++)
        d_rnd[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'(0) : CW'($urandom_range(1, 9));
      drive(NREQ'($urandom), d_rnd, ($urandom_range(0, 40) == 0), $urandom_range(1, 12));
    end
    drive('0, '0, 1'b0, 3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
